// File: rtl/lut_loader_pkg.sv
// lut_loader_pkg
//   Shared definitions for the runtime-programmable LUT neuron bank.
//   - state_t and ST_* : loader FSM state encoding (IDLE, LOAD, DRAIN, READY, ERROR)
//   - lut_depth()      : entries per neuron table (2**IN_BITS)
//   - lut_total()      : number of LOAD_W-wide data beats in one image
//   - lut_cnt_w()      : beat counter width, clog2(TOTAL+1), at least 1
package lut_loader_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_LOAD  = 3'd1;
   localparam state_t ST_DRAIN = 3'd2;
   localparam state_t ST_READY = 3'd3;
   localparam state_t ST_ERROR = 3'd4;

   function automatic int lut_depth(input int in_bits);
      return 1 << in_bits;
   endfunction

   function automatic int lut_total(input int num_neurons, input int in_bits,
                                    input int out_bits, input int load_w);
      return (num_neurons * (1 << in_bits) * out_bits) / load_w;
   endfunction

   function automatic int lut_cnt_w(input int total);
      return ($clog2(total + 1) < 1) ? 1 : $clog2(total + 1);
   endfunction

endpackage

// File: rtl/lut_table_bank.sv
// lut_table_bank
//   Flat register array holding every neuron's truth table, written one
//   LOAD_W-wide beat at a time and read by all neurons in parallel.
//   Ports:
//     clk      in   clock, rising edge (table registers are not reset)
//     wr_en    in   write beat wr_data at beat index wr_idx
//     wr_idx   in   beat index, bits [wr_idx*LOAD_W +: LOAD_W] of the image
//     wr_data  in   beat contents, bit 0 = lowest image bit of the beat
//     rd_addr  in   neuron n entry address at [n*IN_BITS +: IN_BITS]
//     rd_data  out  neuron n entry at [n*OUT_BITS +: OUT_BITS] (combinational)
module lut_table_bank import lut_loader_pkg::*; #(
   parameter int NUM_NEURONS = 16,
   parameter int IN_BITS     = 6,
   parameter int OUT_BITS    = 1,
   parameter int LOAD_W      = 8,
   parameter int IDX_W       = 8
) (
   input  logic                            clk,
   input  logic                            wr_en,
   input  logic [IDX_W-1:0]                wr_idx,
   input  logic [LOAD_W-1:0]               wr_data,
   input  logic [NUM_NEURONS*IN_BITS-1:0]  rd_addr,
   output logic [NUM_NEURONS*OUT_BITS-1:0] rd_data
);

   localparam int DEPTH = lut_depth(IN_BITS);
   localparam int NBITS = NUM_NEURONS * DEPTH * OUT_BITS;

   logic [NBITS-1:0] mem_q;
   logic [NBITS-1:0] mem_d;

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[int'(wr_idx)*LOAD_W +: LOAD_W] = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Image layout: bit (n*DEPTH + e)*OUT_BITS + b is neuron n, entry e, bit b.
   always_comb begin
      rd_data = '0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
         rd_data[n*OUT_BITS +: OUT_BITS] =
            mem_q[(n*DEPTH + int'(rd_addr[n*IN_BITS +: IN_BITS]))*OUT_BITS +: OUT_BITS];
      end
   end

endmodule

// File: rtl/lut_neuron_loader.sv
// lut_neuron_loader
//   Bank of runtime-programmable LUT neurons. A truth-table image is
//   streamed over the cfg_* valid/ready port; once a complete image has
//   landed the bank answers parallel lookups with one cycle of latency.
//   Optional feature macro: LUT_LOADER_CHECKSUM_EN appends one checksum
//   beat (XOR of all data beats) to the image and verifies it.
//   Handshake: a beat transfers on a rising edge where cfg_valid & cfg_ready;
//   a lookup transfers where in_valid & in_ready. cfg_ready is always 1;
//   in_ready is 1 only in READY. out_valid is a one-cycle pulse with no
//   backpressure.
//   Ports:
//     clk, rst_n           clock / asynchronous active-low reset
//     cfg_valid/ready      config beat handshake
//     cfg_data, cfg_last   beat contents (LSB first) and end-of-image flag
//     in_valid/in_ready    lookup request handshake
//     in_addr              per-neuron lookup addresses
//     out_valid, out_data  registered lookup results
//     loaded, load_err     state == READY / state == ERROR
//     dbg_state            current FSM state
module lut_neuron_loader import lut_loader_pkg::*; #(
   parameter int NUM_NEURONS = 16,
   parameter int IN_BITS     = 6,
   parameter int OUT_BITS    = 1,
   parameter int LOAD_W      = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            cfg_valid,
   output logic                            cfg_ready,
   input  logic [LOAD_W-1:0]               cfg_data,
   input  logic                            cfg_last,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [NUM_NEURONS*IN_BITS-1:0]  in_addr,
   output logic                            out_valid,
   output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
   output logic                            loaded,
   output logic                            load_err,
   output state_t                          dbg_state
);

   localparam int TOTAL = lut_total(NUM_NEURONS, IN_BITS, OUT_BITS, LOAD_W);
   localparam int CNT_W = lut_cnt_w(TOTAL);
`ifdef LUT_LOADER_CHECKSUM_EN
   localparam int NBEATS = TOTAL + 1;
`else
   localparam int NBEATS = TOTAL;
`endif
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBEATS - 1);

   state_t                          state_q, state_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic                            out_valid_q, out_valid_d;
   logic [NUM_NEURONS*OUT_BITS-1:0] out_data_q, out_data_d;
   logic [NUM_NEURONS*OUT_BITS-1:0] lut_rd;
   logic                            wr_en;
   logic [CNT_W-1:0]                wr_idx;
   logic                            last_ok;
   logic                            lookup;

`ifdef LUT_LOADER_CHECKSUM_EN
   logic [LOAD_W-1:0] acc_q, acc_d;
   // The final beat must equal the XOR of every data beat before it.
   assign last_ok = (acc_q == cfg_data);
`else
   assign last_ok = 1'b1;
`endif

   assign lookup = in_valid && (state_q == ST_READY);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      wr_idx  = cnt_q;
`ifdef LUT_LOADER_CHECKSUM_EN
      acc_d   = acc_q;
`endif
      case (state_q)
         ST_IDLE, ST_READY, ST_ERROR: begin
            // Any beat here is beat 0 of a fresh image.
            if (cfg_valid) begin
               wr_en  = 1'b1;
               wr_idx = '0;
               cnt_d  = CNT_W'(1);
`ifdef LUT_LOADER_CHECKSUM_EN
               acc_d  = cfg_data;
`endif
               if (NBEATS == 1) begin
                  state_d = cfg_last ? (last_ok ? ST_READY : ST_ERROR) : ST_DRAIN;
               end else begin
                  state_d = cfg_last ? ST_ERROR : ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (cfg_valid) begin
               // The checksum beat (index TOTAL) is compared, not stored.
               wr_en = (int'(cnt_q) < TOTAL);
`ifdef LUT_LOADER_CHECKSUM_EN
               if (int'(cnt_q) < TOTAL) begin
                  acc_d = acc_q ^ cfg_data;
               end
`endif
               if (cnt_q == LAST_IDX) begin
                  if (cfg_last) begin
                     state_d = last_ok ? ST_READY : ST_ERROR;
                  end else begin
                     state_d = ST_DRAIN;
                  end
               end else if (cfg_last) begin
                  state_d = ST_ERROR;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            // Overlength image: swallow beats until the sender ends it.
            if (cfg_valid && cfg_last) begin
               state_d = ST_ERROR;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Reads use the pre-edge table, so a lookup that coincides with a
   // config write sees the old contents.
   always_comb begin
      out_valid_d = lookup;
      out_data_d  = lookup ? lut_rd : out_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

`ifdef LUT_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end
`endif

   lut_table_bank #(
      .NUM_NEURONS (NUM_NEURONS),
      .IN_BITS     (IN_BITS),
      .OUT_BITS    (OUT_BITS),
      .LOAD_W      (LOAD_W),
      .IDX_W       (CNT_W)
   ) u_bank (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_data (cfg_data),
      .rd_addr (in_addr),
      .rd_data (lut_rd)
   );

   assign cfg_ready = 1'b1;
   assign in_ready  = (state_q == ST_READY);
   assign loaded    = (state_q == ST_READY);
   assign load_err  = (state_q == ST_ERROR);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_lut_neuron_loader.sv
// tb_lut_neuron_loader
//   Self-checking bench for lut_neuron_loader at default parameters.
//   The reference keeps the last successfully loaded image as a flat bit
//   vector and answers lookups straight from the image bit-order rule.
//   Build with LUT_LOADER_CHECKSUM_EN to cover the checksum variant.
module tb_lut_neuron_loader;
   import lut_loader_pkg::*;

   localparam int NN    = 16;
   localparam int IB    = 6;
   localparam int OB    = 1;
   localparam int LW    = 8;
   localparam int DEPTH = 64;
   localparam int NBITS = NN * DEPTH * OB;
   localparam int TOTAL = NBITS / LW;
`ifdef LUT_LOADER_CHECKSUM_EN
   localparam int NB = TOTAL + 1;
`else
   localparam int NB = TOTAL;
`endif

   logic                 clk;
   logic                 rst_n;
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [LW-1:0]        cfg_data;
   logic                 cfg_last;
   logic                 in_valid;
   logic                 in_ready;
   logic [NN*IB-1:0]     in_addr;
   logic                 out_valid;
   logic [NN*OB-1:0]     out_data;
   logic                 loaded;
   logic                 load_err;
   state_t               dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   logic [NBITS-1:0] img_bits;     // image currently being streamed
   logic [NBITS-1:0] ref_bits;     // last image that loaded successfully
   logic [LW-1:0]    csum_flip;    // corrupts the checksum beat when nonzero
   logic [NN*OB-1:0] exp_q[$];

   lut_neuron_loader #(
      .NUM_NEURONS (NN),
      .IN_BITS     (IB),
      .OUT_BITS    (OB),
      .LOAD_W      (LW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_data  (cfg_data),
      .cfg_last  (cfg_last),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_addr   (in_addr),
      .out_valid (out_valid),
      .out_data  (out_data),
      .loaded    (loaded),
      .load_err  (load_err),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [NN*OB-1:0] model_lookup(input logic [NN*IB-1:0] a);
      logic [NN*OB-1:0] r;
      r = '0;
      for (int n = 0; n < NN; n++) begin
         for (int b = 0; b < OB; b++) begin
            r[n*OB + b] = ref_bits[(n*DEPTH + int'(a[n*IB +: IB]))*OB + b];
         end
      end
      return r;
   endfunction

   function automatic logic [LW-1:0] image_csum();
      logic [LW-1:0] x;
      x = '0;
      for (int i = 0; i < TOTAL; i++) x ^= img_bits[i*LW +: LW];
      return x;
   endfunction

   function automatic logic [LW-1:0] beat_value(input int i);
      if (i < TOTAL) return img_bits[i*LW +: LW];
      if (i == TOTAL) return image_csum() ^ csum_flip;
      return LW'($urandom);
   endfunction

   task automatic fill_random();
      for (int i = 0; i < NBITS / 32; i++) img_bits[i*32 +: 32] = $urandom;
   endtask

   task automatic fill_const(input logic [LW-1:0] v);
      for (int i = 0; i < TOTAL; i++) img_bits[i*LW +: LW] = v;
   endtask

   // ---------------- drivers ----------------
   // Streams beats from..to back to back; cfg_last rides on beat last_at.
   task automatic send_range(input int from, input int to, input int last_at);
      for (int i = from; i <= to; i++) begin
         @(negedge clk);
         check("cfg_ready", cfg_ready, 1'b1);
         cfg_valid = 1'b1;
         cfg_data  = beat_value(i);
         cfg_last  = (i == last_at);
      end
      @(negedge clk);
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
   endtask

   task automatic expect_flags(input string tag, input logic ld, input logic er, input state_t st);
      check({tag, "_loaded"}, loaded, ld);
      check({tag, "_load_err"}, load_err, er);
      check({tag, "_in_ready"}, in_ready, ld);
      check({tag, "_state"}, dbg_state, st);
   endtask

   task automatic load_good(input string tag);
      send_range(0, NB - 1, NB - 1);
      expect_flags(tag, 1'b1, 1'b0, ST_READY);
      ref_bits = img_bits;
   endtask

   // Back-to-back lookups; results are popped from exp_q one cycle later.
   task automatic run_lookups(input string tag, input int cnt, input bit use_fixed,
                              input logic [NN*IB-1:0] fixed);
      bit pend;
      logic [NN*IB-1:0] a;
      pend = 1'b0;
      for (int i = 0; i <= cnt; i++) begin
         @(negedge clk);
         if (pend) begin
            check({tag, "_out_valid"}, out_valid, 1'b1);
            check({tag, "_out_data"}, out_data, exp_q.pop_front());
         end
         if (i < cnt) begin
            if (use_fixed) a = fixed;
            else for (int n = 0; n < NN; n++) a[n*IB +: IB] = IB'($urandom_range(0, DEPTH - 1));
            in_valid = 1'b1;
            in_addr  = a;
            exp_q.push_back(model_lookup(a));
            pend = 1'b1;
         end else begin
            in_valid = 1'b0;
            pend = 1'b0;
         end
      end
      @(negedge clk);
      check({tag, "_out_valid_drop"}, out_valid, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [NN*IB-1:0] a;
      logic [NN*OB-1:0] e;
      rst_n     = 1'b0;
      cfg_valid = 1'b0;
      cfg_data  = '0;
      cfg_last  = 1'b0;
      in_valid  = 1'b0;
      in_addr   = '0;
      csum_flip = '0;
      img_bits  = '0;
      ref_bits  = '0;

      // Reset state, and lookups refused while unprogrammed.
      repeat (3) @(negedge clk);
      expect_flags("reset", 1'b0, 1'b0, ST_IDLE);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_out_data", out_data, '0);
      rst_n    = 1'b1;
      in_valid = 1'b1;
      in_addr  = {NN{6'h15}};
      repeat (2) begin
         @(negedge clk);
         check("idle_in_ready", in_ready, 1'b0);
         check("idle_out_valid", out_valid, 1'b0);
         check("idle_out_data", out_data, '0);
      end
      in_valid = 1'b0;

      // All-0xAA image: even entries 0, odd entries 1.
      fill_const(8'hAA);
      load_good("aa");
      run_lookups("aa_addr1", 1, 1'b1, {NN{6'h01}});
      run_lookups("aa_addr0", 1, 1'b1, {NN{6'h00}});
      run_lookups("aa_rand", 8, 1'b0, '0);

      // Only neuron 3 all ones, back-to-back lookups.
      img_bits = '0;
      img_bits[3*DEPTH*OB +: DEPTH*OB] = '1;
      load_good("n3");
      run_lookups("n3", 12, 1'b0, '0);

      // Random image, longer random lookup burst.
      fill_random();
      load_good("rnd");
      run_lookups("rnd", 40, 1'b0, '0);

      // Lookup and config beat in the same READY cycle: old contents returned.
      fill_random();
      @(negedge clk);
      for (int n = 0; n < NN; n++) a[n*IB +: IB] = IB'($urandom_range(0, DEPTH - 1));
      e         = model_lookup(a);
      in_valid  = 1'b1;
      in_addr   = a;
      cfg_valid = 1'b1;
      cfg_data  = beat_value(0);
      cfg_last  = 1'b0;
      @(negedge clk);
      in_valid  = 1'b0;
      cfg_valid = 1'b0;
      check("overlap_out_valid", out_valid, 1'b1);
      check("overlap_out_data", out_data, e);
      expect_flags("overlap", 1'b0, 1'b0, ST_LOAD);
      send_range(1, NB - 1, NB - 1);
      expect_flags("overlap_done", 1'b1, 1'b0, ST_READY);
      ref_bits = img_bits;
      run_lookups("overlap_new", 16, 1'b0, '0);

      // Early cfg_last: error, lookups blocked.
      fill_random();
      send_range(0, 50, 50);
      expect_flags("early", 1'b0, 1'b1, ST_ERROR);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("err_out_valid", out_valid, 1'b0);
      fill_random();
      load_good("recover");
      run_lookups("recover", 16, 1'b0, '0);

      // A single beat flagged last from READY starts and ends an image.
      send_range(0, 0, 0);
      expect_flags("one_beat", 1'b0, 1'b1, ST_ERROR);

      // Overlength image: DRAIN after the last index, error on cfg_last.
      fill_random();
      send_range(0, NB - 1, -1);
      expect_flags("drain", 1'b0, 1'b0, ST_DRAIN);
      send_range(NB, NB + 1, NB + 1);
      expect_flags("drain_end", 1'b0, 1'b1, ST_ERROR);

`ifdef LUT_LOADER_CHECKSUM_EN
      // Checksum variant: good and corrupted checksum, and a missing one.
      fill_const(8'h5A);
      csum_flip = 8'h00;
      load_good("csum_ok");
      run_lookups("csum_ok", 8, 1'b0, '0);
      csum_flip = 8'h01;
      send_range(0, NB - 1, NB - 1);
      expect_flags("csum_bad", 1'b0, 1'b1, ST_ERROR);
      csum_flip = 8'h00;
      send_range(0, TOTAL - 1, TOTAL - 1);
      expect_flags("csum_missing", 1'b0, 1'b1, ST_ERROR);
      fill_random();
      load_good("csum_rnd");
      run_lookups("csum_rnd", 8, 1'b0, '0);
`endif

      // Reset in the middle of a load returns to IDLE.
      fill_random();
      send_range(0, 39, -1);
      expect_flags("midload", 1'b0, 1'b0, ST_LOAD);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      expect_flags("midload_rst", 1'b0, 1'b0, ST_IDLE);
      check("midload_rst_out_valid", out_valid, 1'b0);
      rst_n = 1'b1;
      fill_random();
      load_good("after_rst");
      run_lookups("after_rst", 16, 1'b0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lut_neuron_loader.md
# lut_neuron_loader

Runtime-programmable bank of LUT neurons for the LogicNets layer fabric. Accepts a streamed truth-table image over a valid/ready configuration port and holds one table per neuron in registers. Serves registered lookups of all neurons in parallel. It is the writer side of the fixed-ROM neurons: the same truth tables can be updated after synthesis instead of being baked in.

## Interface
Parameters:
- NUM_NEURONS, 16, neurons in the bank
- IN_BITS, 6, address bits per neuron; table depth DEPTH = 2**IN_BITS
- OUT_BITS, 1, output bits per table entry
- LOAD_W, 8, config beat width; NUM_NEURONS*DEPTH*OUT_BITS must be a multiple of LOAD_W; TOTAL = that product / LOAD_W (128 at defaults)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active low
- cfg_valid  in  1  config beat valid
- cfg_ready  out  1  config beat accepted when valid & ready
- cfg_data  in  LOAD_W  table bits, LSB first
- cfg_last  in  1  final beat of image
- in_valid  in  1  lookup request
- in_ready  out  1  high only in READY
- in_addr  in  NUM_NEURONS*IN_BITS  neuron n address at [n*IN_BITS +: IN_BITS]
- out_valid  out  1  lookup result valid, single-cycle pulse, no backpressure
- out_data  out  NUM_NEURONS*OUT_BITS  neuron n result at [n*OUT_BITS +: OUT_BITS]
- loaded  out  1  state == READY
- load_err  out  1  state == ERROR

## Operation
- Image bit order: flat bit k = (n*DEPTH + e)*OUT_BITS + b, for neuron n, entry e, output bit b; beat i carries bits i*LOAD_W .. i*LOAD_W+LOAD_W-1, bit 0 first.
- States: IDLE (unprogrammed), LOAD, DRAIN, READY, ERROR.
- cfg_ready = 1 in every state.
- A beat accepted in IDLE, READY or ERROR starts a new image as beat 0 and enters LOAD. If that beat also has cfg_last and TOTAL != 1, go to ERROR.
- In LOAD, the beat counter increments per accepted beat and each beat is written into the table at its index.
- cfg_last on beat TOTAL-1 -> READY.
- cfg_last on an earlier beat -> ERROR.
- Beat TOTAL-1 without cfg_last -> DRAIN. DRAIN discards beats until cfg_last, then goes to ERROR.
- Tables are partially overwritten on an error. Contents in ERROR are undefined for use; lookups are blocked.
- Lookup: accepted when in_valid & in_ready. The next cycle gives out_valid = 1 and out_data[n] = table[n][in_addr[n]].

## Timing
- Reset values: state IDLE, counter 0, out_valid 0, out_data 0, loaded 0, load_err 0. Table registers are not reset.
- Lookup latency is 1 cycle, with full throughput: one result per cycle under back-to-back requests.
- If a lookup and a config beat are accepted in the same READY cycle, the lookup returns the pre-write contents. in_ready drops the next cycle.
- Config write takes effect at the clock edge of acceptance. The READY transition is visible the cycle after the last beat.
- Reset mid-load returns to IDLE. Partial contents are discarded logically (loaded = 0).
- Counter width is clog2(TOTAL+1). It never wraps, because DRAIN absorbs overlength images.

## Configuration
- LUT_LOADER_CHECKSUM_EN defined:
  - The image is TOTAL+1 beats. The extra final beat, flagged with cfg_last, is a checksum equal to the XOR of all TOTAL data beats.
  - A running XOR accumulator resets on beat 0.
  - A mismatch on the final beat -> ERROR; a match -> READY.
  - cfg_last on beat TOTAL-1 -> ERROR.
  - Length checks move by one beat.
- Undefined: no accumulator; image is exactly TOTAL beats.

## Structure
- Shared package lut_loader_pkg holds:
  - state enum (IDLE, LOAD, DRAIN, READY, ERROR)
  - localparam helpers for DEPTH, TOTAL and counter width
- One sub-module, lut_table_bank:
  - flat NUM_NEURONS*DEPTH*OUT_BITS register array with LOAD_W-wide write at beat index
  - per-neuron combinational read mux
- The top level holds the FSM, beat counter, optional checksum and output register.

## Test plan
- Reset, then in_valid=1 -> in_ready=0, out_valid stays 0; loaded=0, load_err=0.
- Load 128 beats, all 8'hAA, last on beat 127 -> loaded=1 the next cycle. Lookup all addresses 6'h01 -> out_data all 1 after one cycle; addresses 6'h00 -> all 0.
- Load an image where neuron 3 is all-ones and the others are zero. Issue back-to-back lookups -> out_valid high every cycle, and only bit 3 is set.
- cfg_last on beat 50 -> load_err=1, in_ready=0. A fresh 128-beat load then -> loaded=1, load_err=0.
- 130 beats with last on beat 129 -> DRAIN after beat 127, load_err=1 after beat 129.
- With LUT_LOADER_CHECKSUM_EN:
  - 128 beats of 8'h5A followed by checksum 8'h00 -> loaded=1.
  - The same image with checksum 8'h01 -> load_err=1.
